// File: rtl/spi_pkg.sv
// Shared SPI engine definitions: FSM state encoding, SPI mode constants
// ({cpol, cpha}) and a helper that classifies an SCLK edge as a sample edge.
package spi_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned EDGES  = 16;
    localparam int unsigned EDGE_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // SPI modes encoded as {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // MISO is sampled on leading edges when cpha=0, on trailing edges when cpha=1
    function automatic logic is_sample_edge(input logic [1:0] mode, input logic leading);
        logic s;
        case (mode)
            MODE0, MODE2: s = leading;
            MODE1, MODE3: s = ~leading;
            default:      s = leading;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/int_sync.sv
// Peripheral interrupt front end: 2-flop synchronizer plus rising-edge latch.
// Ports: clk, rst_n (async active-low), int_async (raw INT pin),
//        int_ack (clear request), int_pending (latched edge, registered).
module int_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic int_async,
    input  logic int_ack,
    output logic int_pending
);

    // [0],[1]: synchronizer stages; [2]: previous synchronized level
    logic [2:0] sync_q;
    logic       rise_c;

    assign rise_c = sync_q[1] & ~sync_q[2];

    // A new edge wins over a simultaneous acknowledge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            int_pending <= 1'b0;
        end else begin
            sync_q      <= {sync_q[1:0], int_async};
            int_pending <= rise_c | (int_pending & ~int_ack);
        end
    end

endmodule

// File: rtl/spi_engine.sv
// Single-byte SPI master with programmable SCLK divider and CPOL/CPHA.
// Ports: CLK, RESET_N (async active-low); tx_data/tx_valid/tx_ready byte
// handshake; rx_data/rx_valid received byte strobe; div/cpol/cpha transfer
// settings captured on acceptance; ss_assert chip-select request; busy;
// int_pending/int_ack latched interrupt; SS/SCLK/MOSI/MISO/INT SPI pins.
module spi_engine
    import spi_pkg::*;
#(
    parameter int unsigned DIV_W = 8
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [DIV_W-1:0]  div,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              ss_assert,
    output logic              busy,
    output logic              int_pending,
    input  logic              int_ack,
    output logic              SS,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO,
    input  logic              INT
);

    state_t              state;
    logic [DIV_W-1:0]    div_q;
    logic [DIV_W-1:0]    cnt;
    logic                cpol_q;
    logic                cpha_q;
    logic [DATA_W-1:0]   tx_sr;
    logic [DATA_W-1:0]   rx_sr;
    logic [EDGE_W-1:0]   edge_cnt;

    logic                edge_c;
    logic                sample_c;
    logic                drive_c;
    logic                last_c;
    logic [DATA_W-1:0]   rx_shift_c;

    // edge_cnt counts edges already issued, so an even count means the next one leads
    assign edge_c     = (state == ST_SHIFT) && (cnt == '0);
    assign last_c     = edge_c && (edge_cnt == EDGE_W'(EDGES - 1));
    assign sample_c   = edge_c && is_sample_edge({cpol_q, cpha_q}, ~edge_cnt[0]);
    assign drive_c    = edge_c && !sample_c && !last_c;
    assign rx_shift_c = {rx_sr[DATA_W-2:0], MISO};

    // Transfer FSM with registered SPI pins and handshake outputs
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= ST_IDLE;
            div_q    <= '0;
            cnt      <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            edge_cnt <= '0;
            tx_ready <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            busy     <= 1'b0;
            SS       <= 1'b1;
            SCLK     <= 1'b0;
            MOSI     <= 1'b1;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tx_ready <= 1'b1;
                    busy     <= 1'b0;
                    SS       <= ~ss_assert;
                    SCLK     <= cpol;
                    MOSI     <= 1'b1;
                    if (tx_valid && tx_ready) begin
                        state    <= ST_SHIFT;
                        tx_ready <= 1'b0;
                        busy     <= 1'b1;
                        div_q    <= div;
                        cnt      <= div;
                        cpol_q   <= cpol;
                        cpha_q   <= cpha;
                        edge_cnt <= '0;
                        rx_sr    <= '0;
                        // cpha=0 puts bit 7 out immediately; cpha=1 waits for the leading edge
                        if (cpha) begin
                            tx_sr <= tx_data;
                            MOSI  <= 1'b1;
                        end else begin
                            tx_sr <= {tx_data[DATA_W-2:0], 1'b0};
                            MOSI  <= tx_data[DATA_W-1];
                        end
                    end
                end

                ST_SHIFT: begin
                    // Chip select may assert but not release mid-transfer
                    SS <= SS & ~ss_assert;
                    if (edge_c) begin
                        cnt      <= div_q;
                        SCLK     <= ~SCLK;
                        edge_cnt <= edge_cnt + EDGE_W'(1);
                        if (sample_c) begin
                            rx_sr <= rx_shift_c;
                        end
                        if (drive_c) begin
                            MOSI  <= tx_sr[DATA_W-1];
                            tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
                        end
                        if (last_c) begin
                            state    <= ST_DONE;
                            rx_valid <= 1'b1;
                            rx_data  <= sample_c ? rx_shift_c : rx_sr;
                        end
                    end else begin
                        cnt <= cnt - DIV_W'(1);
                    end
                end

                ST_DONE: begin
                    state    <= ST_IDLE;
                    tx_ready <= 1'b1;
                    busy     <= 1'b0;
                    SS       <= ~ss_assert;
                    SCLK     <= cpol_q;
                    MOSI     <= 1'b1;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    int_sync u_int_sync (
        .clk         (CLK),
        .rst_n       (RESET_N),
        .int_async   (INT),
        .int_ack     (int_ack),
        .int_pending (int_pending)
    );

endmodule

// File: tb/tb_spi_engine.sv
// Self-checking bench for spi_engine: expected SPI timing, bit order and
// received data are derived arithmetically from edge counts since acceptance.
module tb_spi_engine;
    import spi_pkg::*;

    localparam int unsigned DIV_W = 8;

    logic             CLK = 1'b0;
    logic             RESET_N = 1'b0;
    logic [7:0]       tx_data = '0;
    logic             tx_valid = 1'b0;
    logic             tx_ready;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic [DIV_W-1:0] div = '0;
    logic             cpol = 1'b0;
    logic             cpha = 1'b0;
    logic             ss_assert = 1'b0;
    logic             busy;
    logic             int_pending;
    logic             int_ack = 1'b0;
    logic             SS;
    logic             SCLK;
    logic             MOSI;
    logic             MISO = 1'b0;
    logic             INT = 1'b0;

    int total = 0;
    int bad   = 0;

    spi_engine #(.DIV_W(DIV_W)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .div(div), .cpol(cpol), .cpha(cpha), .ss_assert(ss_assert),
        .busy(busy), .int_pending(int_pending), .int_ack(int_ack),
        .SS(SS), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .INT(INT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected reset-state values on every output
    task automatic check_reset_values(input string tag);
        total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL %s tx_ready got=%b want=0", tag, tx_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s busy got=%b want=0", tag, busy); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL %s rx_valid got=%b want=0", tag, rx_valid); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL %s rx_data got=%h want=00", tag, rx_data); end
        total++; if (SS !== 1'b1) begin bad++; $display("FAIL %s SS got=%b want=1", tag, SS); end
        total++; if (SCLK !== 1'b0) begin bad++; $display("FAIL %s SCLK got=%b want=0", tag, SCLK); end
        total++; if (MOSI !== 1'b1) begin bad++; $display("FAIL %s MOSI got=%b want=1", tag, MOSI); end
        total++; if (int_pending !== 1'b0) begin bad++; $display("FAIL %s int_pending got=%b want=0", tag, int_pending); end
    endtask

    // One complete transfer; caller is at a negedge. Checks every cycle.
    // n = number of rising edges since the accepting edge; edges occur every dv+1.
    task automatic xfer(input logic [7:0] data, input logic [7:0] miso_b, input int dv,
                        input logic [1:0] mode, input bit scramble, input int drop_at);
        int   last, e, s, k;
        logic pol, pha, ss_acc, ss_done, exp_mosi;
        pol = mode[1];
        pha = mode[0];
        last = 16 * (dv + 1);
        ss_done = ss_assert;
        tx_data = data; div = DIV_W'(dv); cpol = pol; cpha = pha; tx_valid = 1'b1;
        MISO = miso_b[7];
        k = 0;
        while (!tx_ready && k < 100) begin @(negedge CLK); k++; end
        total++;
        if (tx_ready !== 1'b1) begin
            bad++; $display("FAIL accept_timeout tx_ready got=%b want=1", tx_ready);
            tx_valid = 1'b0;
            return;
        end
        ss_acc = ss_assert;
        @(posedge CLK);
        for (int n = 0; n <= last + 1; n++) begin
            @(negedge CLK);
            if (n == 0) begin
                tx_valid = 1'b0;
                if (scramble) begin
                    tx_data = 8'($urandom); div = DIV_W'($urandom_range(0, 5));
                    cpol = 1'($urandom); cpha = 1'($urandom);
                end
            end
            if (n == drop_at) ss_assert = 1'b0;
            e = n / (dv + 1);
            if (e > 16) e = 16;
            if (n <= last) begin
                total++; if (SCLK !== (pol ^ (e % 2 == 1))) begin bad++; $display("FAIL sclk n=%0d got=%b want=%b", n, SCLK, pol ^ (e % 2 == 1)); end
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy n=%0d got=%b want=1", n, busy); end
                total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL tx_ready_shift n=%0d got=%b want=0", n, tx_ready); end
                total++; if (rx_valid !== (n == last)) begin bad++; $display("FAIL rx_valid n=%0d got=%b want=%b", n, rx_valid, n == last); end
                total++; if (SS !== ~ss_acc) begin bad++; $display("FAIL ss_shift n=%0d got=%b want=%b", n, SS, ~ss_acc); end
                if (n < last && (!pha || e >= 1)) begin
                    exp_mosi = pha ? data[7 - (e - 1) / 2] : data[7 - e / 2];
                    total++; if (MOSI !== exp_mosi) begin bad++; $display("FAIL mosi n=%0d got=%b want=%b", n, MOSI, exp_mosi); end
                end
                if (n == last) begin
                    total++; if (rx_data !== miso_b) begin bad++; $display("FAIL rx_data got=%h want=%h", rx_data, miso_b); end
                    ss_done = ss_assert;
                end
            end else begin
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_idle got=%b want=0", busy); end
                total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL tx_ready_idle got=%b want=1", tx_ready); end
                total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rx_valid_idle got=%b want=0", rx_valid); end
                total++; if (MOSI !== 1'b1) begin bad++; $display("FAIL mosi_idle got=%b want=1", MOSI); end
                total++; if (rx_data !== miso_b) begin bad++; $display("FAIL rx_data_hold got=%h want=%h", rx_data, miso_b); end
                total++; if (SS !== ~ss_done) begin bad++; $display("FAIL ss_idle got=%b want=%b", SS, ~ss_done); end
            end
            // Slave model: present the next unsampled bit of miso_b
            s = pha ? e / 2 : (e + 1) / 2;
            MISO = (s < 8) ? miso_b[7 - s] : 1'b0;
        end
    endtask

    task automatic test_reset;
        RESET_N = 1'b0;
        repeat (3) @(negedge CLK);
        check_reset_values("reset_hold");
        RESET_N = 1'b1;
        @(negedge CLK);
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset got=%b want=1", tx_ready); end
    endtask

    task automatic test_idle;
        logic [1:0] v;
        for (int i = 0; i < 4; i++) begin
            v = 2'(i);
            cpol = v[1]; ss_assert = v[0];
            @(negedge CLK);
            total++; if (SCLK !== cpol) begin bad++; $display("FAIL idle_sclk got=%b want=%b", SCLK, cpol); end
            total++; if (SS !== ~ss_assert) begin bad++; $display("FAIL idle_ss got=%b want=%b", SS, ~ss_assert); end
            total++; if (MOSI !== 1'b1) begin bad++; $display("FAIL idle_mosi got=%b want=1", MOSI); end
        end
        ss_assert = 1'b0; cpol = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_directed;
        logic [7:0] r;
        xfer(8'hA5, 8'hA5, 0, MODE0, 1'b0, -1);
        cpol = 1'b1;
        repeat (2) @(negedge CLK);
        total++; if (SCLK !== 1'b1) begin bad++; $display("FAIL mode3_idle_sclk got=%b want=1", SCLK); end
        xfer(8'h3C, 8'hFF, 3, MODE3, 1'b0, -1);
        r = 8'($urandom);
        xfer(8'h5A, r, 0, MODE1, 1'b1, -1);
        r = 8'($urandom);
        xfer(8'hC3, r, 5, MODE2, 1'b0, -1);
    endtask

    task automatic test_back_to_back;
        ss_assert = 1'b1;
        repeat (2) @(negedge CLK);
        xfer(8'h01, 8'($urandom), 1, MODE0, 1'b0, -1);
        xfer(8'h80, 8'($urandom), 1, MODE0, 1'b0, 5);
        @(negedge CLK);
    endtask

    task automatic test_random;
        logic [1:0] m;
        for (int i = 0; i < 12; i++) begin
            m = 2'($urandom);
            ss_assert = 1'($urandom);
            xfer(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), m, 1'($urandom), -1);
        end
        ss_assert = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_int;
        int got;
        got = 0;
        INT = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge CLK);
            if (k == 3) INT = 1'b0;
            if (int_pending === 1'b1 && got == 0) got = k;
        end
        total++; if (got < 2 || got > 3) begin bad++; $display("FAIL int_latency got=%0d want=2..3", got); end
        int_ack = 1'b1; @(negedge CLK); int_ack = 1'b0; @(negedge CLK);
        total++; if (int_pending !== 1'b0) begin bad++; $display("FAIL int_ack_clear got=%b want=0", int_pending); end
        INT = 1'b1;
        @(negedge CLK);
        @(negedge CLK); int_ack = 1'b1;
        @(negedge CLK); int_ack = 1'b0; INT = 1'b0;
        total++; if (int_pending !== 1'b1) begin bad++; $display("FAIL int_set_vs_ack got=%b want=1", int_pending); end
        repeat (3) @(negedge CLK);
        total++; if (int_pending !== 1'b1) begin bad++; $display("FAIL int_hold got=%b want=1", int_pending); end
        int_ack = 1'b1; @(negedge CLK); int_ack = 1'b0; @(negedge CLK);
        total++; if (int_pending !== 1'b0) begin bad++; $display("FAIL int_lone_ack got=%b want=0", int_pending); end
    endtask

    task automatic test_reset_abort;
        int k, seen;
        INT = 1'b1; repeat (4) @(negedge CLK); INT = 1'b0;
        ss_assert = 1'b1;
        tx_data = 8'h96; div = DIV_W'(1); cpol = 1'b0; cpha = 1'b0; tx_valid = 1'b1;
        k = 0;
        while (!tx_ready && k < 100) begin @(negedge CLK); k++; end
        @(posedge CLK);
        @(negedge CLK); tx_valid = 1'b0;
        // Seventh SCLK edge is 14 rising edges after acceptance
        repeat (13) @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        check_reset_values("reset_abort");
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (rx_valid === 1'b1 || busy === 1'b1) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL abort_no_rx cycles_active=%0d want=0", seen); end
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b want=1", tx_ready); end
        ss_assert = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_directed();
        test_back_to_back();
        test_random();
        test_int();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
